// File: rtl/ceespu_dmem_responder.sv
// Data-memory responder for the ceespu CPU: byte-lane word RAM plus a small IO block
// (free-running COUNT, LEDS, CMP and a sticky MATCH/IRQ_EN status) with one-cycle read latency.
module ceespu_dmem_responder #(
  parameter int RAM_AWIDTH = 10
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [15:0] I_dmemAddress,
  input  logic [31:0] I_dmemWData,
  input  logic        I_dmemE,
  input  logic [3:0]  I_dmemWe,
  output logic [31:0] O_dmemData,
  output logic [7:0]  O_leds,
  output logic        O_irq
);

  localparam int RAM_DEPTH = 1 << RAM_AWIDTH;

  localparam logic [1:0] IO_COUNT  = 2'd0;
  localparam logic [1:0] IO_LEDS   = 2'd1;
  localparam logic [1:0] IO_CMP    = 2'd2;
  localparam logic [1:0] IO_STATUS = 2'd3;

  // Access decode; every access qualifier is gated by reset so nothing lands while I_rst is high
  logic                  acc_en;
  logic                  is_rd;
  logic                  is_wr;
  logic                  is_io;
  logic                  io_hit;
  logic [1:0]            io_sel;
  logic [RAM_AWIDTH-1:0] ram_idx;
  logic                  ram_rd;
  logic                  ram_wr;
  logic                  wr_count;
  logic                  wr_leds;
  logic                  wr_cmp;
  logic                  wr_status;
  logic                  unused_addr_lsbs;

  assign acc_en    = I_dmemE && !I_rst;
  assign is_rd     = acc_en && (I_dmemWe == 4'b0000);
  assign is_wr     = acc_en && (I_dmemWe != 4'b0000);
  assign is_io     = I_dmemAddress[15];
  assign io_hit    = is_io && (I_dmemAddress[14:4] == 11'd0);
  assign io_sel    = I_dmemAddress[3:2];
  assign ram_idx   = I_dmemAddress[RAM_AWIDTH+1:2];
  assign ram_rd    = is_rd && !is_io;
  assign ram_wr    = is_wr && !is_io;
  assign wr_count  = is_wr && io_hit && (io_sel == IO_COUNT);
  assign wr_leds   = is_wr && io_hit && (io_sel == IO_LEDS);
  assign wr_cmp    = is_wr && io_hit && (io_sel == IO_CMP);
  assign wr_status = is_wr && io_hit && (io_sel == IO_STATUS);
  assign unused_addr_lsbs = ^I_dmemAddress[1:0];

  // One byte-wide RAM per lane so each lane infers its own block RAM with a registered read port
  logic [31:0] ram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : lane_g
      logic [7:0] mem [RAM_DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge I_clk) begin
        if (ram_wr && I_dmemWe[gi]) begin
          mem[ram_idx] <= I_dmemWData[gi*8 +: 8];
        end
        if (ram_rd) begin
          rd_q <= mem[ram_idx];
        end
      end

      assign ram_rdata[gi*8 +: 8] = rd_q;
    end
  endgenerate

  // IO register file
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [7:0]  leds_q, leds_d;
  logic        match_q, match_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_q;
  logic        match_clr;

  // Read-data path: the RAM lane registers and io_rdata_q each hold their last value,
  // rd_io_q picks which one is presented, rd_valid_q forces zero until the first read after reset
  logic        rd_valid_q;
  logic        rd_io_q;
  logic [31:0] io_rdata_q, io_rdata_d;

  always_comb begin
    count_d = count_q + 32'd1;
    if (wr_count) begin
      count_d = I_dmemWData;
    end

    leds_d = leds_q;
    if (wr_leds && I_dmemWe[0]) begin
      leds_d = I_dmemWData[7:0];
    end

    cmp_d = cmp_q;
    for (int b = 0; b < 4; b++) begin
      if (wr_cmp && I_dmemWe[b]) begin
        cmp_d[b*8 +: 8] = I_dmemWData[b*8 +: 8];
      end
    end

    // A fresh compare hit outranks a software clear in the same cycle
    match_clr = wr_status && I_dmemWe[0] && I_dmemWData[0];
    match_d   = (count_q == cmp_q) || (match_q && !match_clr);

    irq_en_d = irq_en_q;
    if (wr_status && I_dmemWe[0]) begin
      irq_en_d = I_dmemWData[1];
    end

    io_rdata_d = 32'd0;
    if (io_hit) begin
      case (io_sel)
        IO_COUNT:  io_rdata_d = count_q;
        IO_LEDS:   io_rdata_d = {24'd0, leds_q};
        IO_CMP:    io_rdata_d = cmp_q;
        IO_STATUS: io_rdata_d = {30'd0, irq_en_q, match_q};
        default:   io_rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      count_q    <= 32'd0;
      cmp_q      <= 32'hFFFF_FFFF;
      leds_q     <= 8'd0;
      match_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_io_q    <= 1'b0;
      io_rdata_q <= 32'd0;
    end else begin
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      leds_q   <= leds_d;
      match_q  <= match_d;
      irq_en_q <= irq_en_d;
      irq_q    <= match_d && irq_en_d;
      if (is_rd) begin
        rd_valid_q <= 1'b1;
        rd_io_q    <= is_io;
      end
      if (is_rd && is_io) begin
        io_rdata_q <= io_rdata_d;
      end
    end
  end

  assign O_dmemData = !rd_valid_q ? 32'd0 : (rd_io_q ? io_rdata_q : ram_rdata);
  assign O_leds     = leds_q;
  assign O_irq      = irq_q;

endmodule

// File: tb/tb_ceespu_dmem_responder.sv
// Randomized + directed bench for ceespu_dmem_responder; a spec-level model predicts the
// post-edge outputs each cycle and a separate monitor pops and compares them.
module tb_ceespu_dmem_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        en;
  logic [3:0]  we;
  logic [31:0] dout;
  logic [7:0]  leds;
  logic        irq;

  always #5 clk = ~clk;

  ceespu_dmem_responder #(.RAM_AWIDTH(AW)) dut (
    .I_clk        (clk),
    .I_rst        (rst),
    .I_dmemAddress(addr),
    .I_dmemWData  (wdata),
    .I_dmemE      (en),
    .I_dmemWe     (we),
    .O_dmemData   (dout),
    .O_leds       (leds),
    .O_irq        (irq)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  leds;
    logic        irq;
    bit          rd;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Reference state: what the block's registers hold during the upcoming cycle
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_count, m_cmp, m_out;
  logic [7:0]  m_leds;
  logic        m_match, m_irqen;

  function automatic logic [31:0] io_read(input logic [15:0] a);
    case (a[14:2])
      13'd0:   return m_count;
      13'd1:   return {24'd0, m_leds};
      13'd2:   return m_cmp;
      13'd3:   return {30'd0, m_irqen, m_match};
      default: return 32'd0;
    endcase
  endfunction

  // Drive one cycle of stimulus and advance the model across the following rising edge
  task automatic step(input logic r, input logic e, input logic [3:0] w,
                      input logic [15:0] a, input logic [31:0] d);
    exp_t        x;
    bit          rd, wr, hit, clr;
    logic [31:0] next_count;
    int          idx;
    @(negedge clk);
    rst = r; en = e; we = w; addr = a; wdata = d;
    rd = !r && e && (w == 4'd0);
    wr = !r && e && (w != 4'd0);
    if (r) begin
      m_out = 0; m_leds = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0; m_irqen = 0;
    end else begin
      idx        = int'(a[AW+1:2]);
      hit        = (m_count == m_cmp);
      clr        = 0;
      next_count = m_count + 32'd1;
      if (rd) m_out = a[15] ? io_read(a) : m_mem[idx];
      if (wr && !a[15]) begin
        for (int b = 0; b < 4; b++)
          if (w[b]) m_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      end
      if (wr && a[15] && a[14:4] == 11'd0) begin
        case (a[3:2])
          2'd0: next_count = d;
          2'd1: if (w[0]) m_leds = d[7:0];
          2'd2: for (int b = 0; b < 4; b++) if (w[b]) m_cmp[b*8 +: 8] = d[b*8 +: 8];
          default: if (w[0]) begin clr = d[0]; m_irqen = d[1]; end
        endcase
      end
      m_match = hit || (m_match && !clr);
      m_count = next_count;
    end
    x.data = m_out; x.leds = m_leds; x.irq = m_match & m_irqen; x.rd = rd; x.addr = a;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 16'd0, 32'd0);
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b0, 1'b1, 4'd0, a, 32'd0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
    step(1'b0, 1'b1, w, a, d);
  endtask

  task automatic random_cycle();
    logic        e;
    logic [3:0]  w;
    logic [15:0] a;
    logic [31:0] d;
    e = ($urandom_range(0, 99) < 85);
    if ($urandom_range(0, 3) == 0)
      a = 16'h8000 | 16'($urandom_range(0, 5) << 2) | 16'($urandom_range(0, 3));
    else
      a = 16'($urandom) & 16'h7FFF;
    w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    d = $urandom;
    if (a[15] && w != 0 && a[4:2] == 3'd2) begin
      w = 4'hF;
      d = m_count + 32'($urandom_range(2, 30));
    end
    if (a[15] && w != 0 && a[4:2] == 3'd0) d = m_cmp - 32'($urandom_range(0, 25));
    step(1'b0, e, w, a, d);
  endtask

  // Monitor: one expectation per clock edge, compared 1 time unit after the edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        tests_run++;
        if (dout !== x.data) begin
          tests_failed++;
          $display("[TB] FAIL dmem_data addr=%h got=%h exp=%h", x.addr, dout, x.data);
        end else if (x.rd) begin
          $display("[TB] rd addr=%h data=%h", x.addr, dout);
        end
        tests_run++;
        if (leds !== x.leds) begin
          tests_failed++;
          $display("[TB] FAIL leds got=%h exp=%h", leds, x.leds);
        end
        tests_run++;
        if (irq !== x.irq) begin
          tests_failed++;
          $display("[TB] FAIL irq got=%b exp=%b", irq, x.irq);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; we = 4'd0; addr = 16'd0; wdata = 32'd0;
    m_out = 0; m_leds = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0; m_irqen = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;

    // Reset with an enabled write pending: must not reach RAM
    step(1'b1, 1'b1, 4'hF, 16'h0010, 32'h1111_1111);
    step(1'b1, 1'b0, 4'd0, 16'd0, 32'd0);

    for (int i = 0; i < DEPTH; i++) wr(16'(i << 2), 4'hF, $urandom);

    wr(16'h0010, 4'hF, 32'hDEAD_BEEF);
    rd(16'h0010);
    idle();
    wr(16'h0010, 4'h1, 32'h0000_00AA);
    rd(16'h0010);
    rd(16'h1010);
    idle();

    wr(16'h8004, 4'h1, 32'h0000_005A);
    rd(16'h8004);
    rd(16'h8010);
    wr(16'h8010, 4'hF, 32'hFFFF_FFFF);
    rd(16'h8004);

    wr(16'h8000, 4'hF, 32'hFFFF_FFFE);
    idle();
    rd(16'h8000);
    rd(16'h8000);
    idle();

    wr(16'h8008, 4'hF, 32'd100);
    wr(16'h800C, 4'h1, 32'h3);
    wr(16'h800C, 4'h1, 32'h2);
    wr(16'h8000, 4'hF, 32'd95);
    for (int k = 0; k < 10; k++) idle();
    rd(16'h800C);
    wr(16'h800C, 4'h1, 32'h3);
    idle();
    rd(16'h800C);

    // Clear issued in the very cycle COUNT equals CMP
    wr(16'h8008, 4'hF, 32'd300);
    wr(16'h8000, 4'hF, 32'd290);
    for (int k = 0; k < 50 && m_count != 32'd300; k++) idle();
    wr(16'h800C, 4'h1, 32'h3);
    rd(16'h800C);
    idle();

    for (int i = 0; i < 1500; i++) random_cycle();

    // Reset pulse in the middle of a read burst, with a write attempted under reset
    for (int i = 0; i < 4; i++) rd(16'(i << 2));
    step(1'b1, 1'b1, 4'hF, 16'h0004, 32'hCAFE_F00D);
    idle();
    for (int i = 0; i < 4; i++) rd(16'(i << 2));
    rd(16'h800C);
    rd(16'h8008);

    for (int i = 0; i < 1500; i++) random_cycle();
    idle();
    idle();

    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
